// File: rtl/phase_to_rgb_pipe_pkg.sv
// Shared constants for the phase-to-RGB display path.
// Mode and hue-sector encodings.
package phase_rgb_pkg;

  localparam logic [1:0] MODE_HUE      = 2'b00;
  localparam logic [1:0] MODE_HUE_MAG  = 2'b01;
  localparam logic [1:0] MODE_GRAY     = 2'b10;
  localparam logic [1:0] MODE_GRAY_MAG = 2'b11;

  localparam logic [1:0] SEC_RG = 2'd0;
  localparam logic [1:0] SEC_GB = 2'd1;
  localparam logic [1:0] SEC_BR = 2'd2;

endpackage

// File: rtl/phase_to_rgb_pipe_hue_sector.sv
// Combinational 3-sector hue wheel.
// Phase index p -> R/G/B ramps.
module hue_sector
  import phase_rgb_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic [COLOR_W-1:0] p_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o
);

  logic [COLOR_W+1:0] t;
  logic [1:0]         sec;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] inv;

  // t = 3*p; MAX - r is just the bitwise inverse of r
  assign t   = {2'b00, p_i} + {1'b0, p_i, 1'b0};
  assign sec = t[COLOR_W+1:COLOR_W];
  assign r   = t[COLOR_W-1:0];
  assign inv = ~r;

  // Pick the ramp pair for the sector; sector 3 is unreachable and folds into BR
  always_comb begin
    red_o   = '0;
    green_o = '0;
    blue_o  = '0;
    case (sec)
      SEC_RG: begin
        red_o   = inv;
        green_o = r;
      end
      SEC_GB: begin
        green_o = inv;
        blue_o  = r;
      end
      default: begin
        blue_o = inv;
        red_o  = r;
      end
    endcase
  end

endmodule

// File: rtl/phase_to_rgb_pipe.sv
// Three-stage phase-to-colour mapper with valid/ready.
// S1 rotate/index, S2 hue or gray, S3 brightness.
module phase_to_rgb_pipe
  import phase_rgb_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int COLOR_W = 8,
  parameter int MAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic [PHASE_W-1:0] in_offset,
  input  logic [MAG_W-1:0]   in_mag,
  input  logic [1:0]         in_mode,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] out_red,
  output logic [COLOR_W-1:0] out_green,
  output logic [COLOR_W-1:0] out_blue,
  output logic               out_last
);

  localparam int PW = COLOR_W + MAG_W + 1;

  function automatic logic [COLOR_W-1:0] scale(
    input logic [COLOR_W-1:0] c,
    input logic [MAG_W-1:0]   m
  );
    logic [MAG_W:0] mp1;
    logic [PW-1:0]  prod;
    mp1  = {1'b0, m} + {{MAG_W{1'b0}}, 1'b1};
    prod = PW'(c) * PW'(mp1);
    return prod[MAG_W +: COLOR_W];
  endfunction

  logic en;

  logic               v1_q, last1_q;
  logic [COLOR_W-1:0] p1_q;
  logic [MAG_W-1:0]   mag1_q;
  logic [1:0]         mode1_q;

  logic               v2_q, last2_q, scl2_q;
  logic [COLOR_W-1:0] r2_q, g2_q, b2_q;
  logic [MAG_W-1:0]   mag2_q;

  logic               v3_q, last3_q;
  logic [COLOR_W-1:0] r3_q, g3_q, b3_q;

  logic [PHASE_W-1:0] p_rot;
  logic [COLOR_W-1:0] p1_d;
  logic [COLOR_W-1:0] hr, hg, hb;
  logic               gray;
  logic [COLOR_W-1:0] r2_d, g2_d, b2_d;
  logic [COLOR_W-1:0] r3_d, g3_d, b3_d;

  // Whole pipe freezes only when the output beat is refused
  assign en       = !(v3_q && !out_ready);
  assign in_ready = en;

  assign p_rot = in_phase + in_offset;
  assign p1_d  = p_rot[PHASE_W-1 -: COLOR_W];

  hue_sector #(.COLOR_W(COLOR_W)) u_hue (
    .p_i     (p1_q),
    .red_o   (hr),
    .green_o (hg),
    .blue_o  (hb)
  );

  assign gray = (mode1_q == MODE_GRAY) || (mode1_q == MODE_GRAY_MAG);
  assign r2_d = gray ? p1_q : hr;
  assign g2_d = gray ? p1_q : hg;
  assign b2_d = gray ? p1_q : hb;

  assign r3_d = scl2_q ? scale(r2_q, mag2_q) : r2_q;
  assign g3_d = scl2_q ? scale(g2_q, mag2_q) : g2_q;
  assign b3_d = scl2_q ? scale(b2_q, mag2_q) : b2_q;

  // S1: capture rotated phase index and per-beat sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      p1_q    <= '0;
      mag1_q  <= '0;
      mode1_q <= MODE_HUE;
    end else if (en) begin
      v1_q    <= in_valid;
      last1_q <= in_last;
      p1_q    <= p1_d;
      mag1_q  <= in_mag;
      mode1_q <= in_mode;
    end
  end

  // S2: colour channels from hue wheel or grayscale
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      scl2_q  <= 1'b0;
      r2_q    <= '0;
      g2_q    <= '0;
      b2_q    <= '0;
      mag2_q  <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      last2_q <= last1_q;
      scl2_q  <= mode1_q[0];
      r2_q    <= r2_d;
      g2_q    <= g2_d;
      b2_q    <= b2_d;
      mag2_q  <= mag1_q;
    end
  end

  // S3: optional magnitude scaling into the output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
      r3_q    <= '0;
      g3_q    <= '0;
      b3_q    <= '0;
    end else if (en) begin
      v3_q    <= v2_q;
      last3_q <= last2_q;
      r3_q    <= r3_d;
      g3_q    <= g3_d;
      b3_q    <= b3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_last  = last3_q;
  assign out_red   = r3_q;
  assign out_green = g3_q;
  assign out_blue  = b3_q;

endmodule

// File: tb/tb_phase_to_rgb_pipe.sv
// Scoreboard bench for phase_to_rgb_pipe.
// Random and directed beats vs. arithmetic hue model.
module tb_phase_to_rgb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_phase;
  logic [15:0] in_offset;
  logic [7:0]  in_mag;
  logic [1:0]  in_mode;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_red, out_green, out_blue;
  logic        out_last;

  typedef struct {
    logic [23:0] rgb;
    logic        last;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   bp_en    = 0;

  phase_to_rgb_pipe #(.PHASE_W(16), .COLOR_W(8), .MAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_phase  (in_phase),
    .in_offset (in_offset),
    .in_mag    (in_mag),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_red   (out_red),
    .out_green (out_green),
    .out_blue  (out_blue),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hue wheel from its definition: three 256-wide ramps over 3*p
  function automatic logic [23:0] model(int ph, int off, int mag, int mode);
    int p, h, r, g, b;
    p = ((ph + off) % 65536) / 256;
    if (mode >= 2) begin
      r = p; g = p; b = p;
    end else begin
      h = 3 * p;
      if (h < 256) begin
        r = 255 - h; g = h; b = 0;
      end else if (h < 512) begin
        r = 0; g = 511 - h; b = h - 256;
      end else begin
        r = h - 512; g = 0; b = 767 - h;
      end
    end
    if (mode % 2 == 1) begin
      r = r * (mag + 1) / 256;
      g = g * (mag + 1) / 256;
      b = b * (mag + 1) / 256;
    end
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Offer a beat from a negedge; returns at the negedge after it transferred
  task automatic send(int ph, int off, int mag, int mode, bit last, bit lat);
    exp_t e;
    int   n;
    in_phase  = 16'(ph);
    in_offset = 16'(off);
    in_mag    = 8'(mag);
    in_mode   = 2'(mode);
    in_last   = last;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout phase=%h", ph);
    end else begin
      e.rgb  = model(ph, off, mag, mode);
      e.last = last;
      e.acc  = cyc;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Downstream readiness, changed well clear of both edges
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every presented beat, check hold and in_ready
  initial begin
    bit          stall_q = 0;
    logic [24:0] held    = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_red, out_green, out_blue, out_last}),
              32'(held));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat got=%h", {out_red, out_green, out_blue});
        end else begin
          e = exp_q[0];
          check("pixel", 32'({out_red, out_green, out_blue}), 32'(e.rgb));
          check("last", 32'(out_last), 32'(e.last));
          if (e.lat)
            check("latency", 32'(cyc - e.acc), 32'd3);
          if (out_ready)
            void'(exp_q.pop_front());
        end
      end
      stall_q = out_valid && !out_ready;
      held    = {out_red, out_green, out_blue, out_last};
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_phase  = '0;
    in_offset = '0;
    in_mag    = '0;
    in_mode   = '0;
    in_last   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'({out_valid, out_last, out_red, out_green, out_blue}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(in_ready), 32'd1);

    // Hue points with latency check
    send(16'h0000, 0, 0, 0, 0, 1);
    send(16'h5500, 0, 0, 0, 1, 1);
    send(16'h5600, 0, 0, 0, 0, 1);
    send(16'hFF00, 0, 0, 0, 1, 1);
    // Wrap and its unrotated twin
    send(16'hF000, 16'h2000, 0, 0, 0, 1);
    send(16'h1000, 0, 0, 0, 0, 1);
    // Brightness
    send(0, 0, 8'hFF, 1, 0, 1);
    send(0, 0, 8'h7F, 1, 0, 1);
    send(0, 0, 8'h00, 1, 0, 1);
    // Gray
    send(16'h8000, 0, 8'h3F, 2, 0, 1);
    send(16'h8000, 0, 8'h3F, 3, 1, 1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("model_wrap", 32'(model(16'hF000, 16'h2000, 0, 0)), 32'h00CF3000);

    // Random stream under backpressure
    bp_en = 1;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 65535), $urandom_range(0, 65535),
           $urandom_range(0, 255), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    bp_en = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_bp", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight
    send(16'h1234, 0, 0, 0, 0, 1);
    send(16'h4321, 0, 0, 0, 0, 1);
    send(16'hABCD, 0, 0, 0, 1, 1);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("rst_flush", 32'(out_valid), 32'd0);
    repeat (5) @(negedge clk);
    send(16'h2A00, 16'h0100, 8'h80, 1, 1, 1);
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_end", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
